hazard_sched: RTL and testbench
===============================

# hazard_sched

Pipeline hazard controller that sequences the instruction-decode stage and the PC/IF-ID write enables. It detects load-use hazards between the instruction in ID and a load in EX and inserts exactly one bubble. It turns a taken-branch request into a flush window of programmable length and keeps saturating event counters for debug. It sits beside the ID stage: its `inHazard` and `flush` outputs drive the ID control-bubble mux and the ID/EX register clear.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles `flush` stays high per taken branch; legal range 1..15.
- `CNT_W`, default 16: width of the event counters.

Ports:
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high.
- `idRs`  in  5  rs field of the instruction in ID.
- `idRt`  in  5  rt field of the instruction in ID.
- `idUsesRt`  in  1  ID instruction reads rt as a source (R-type, store, branch).
- `exMemRead`  in  1  instruction in EX is a load.
- `exRt`  in  5  destination rt of the instruction in EX.
- `branchTaken`  in  1  taken branch resolved this cycle (PCSrc).
- `pcWrite`  out  1  PC update enable.
- `ifIdWrite`  out  1  IF/ID register write enable.
- `inHazard`  out  1  forces ID control signals to zero (bubble).
- `flush`  out  1  clears the ID/EX register.
- `stallCount`  out  CNT_W  number of load-use stalls inserted, saturating.
- `flushCount`  out  CNT_W  number of flush windows started, saturating.
- `stepMode`, `stepReq`  in  1 each  present only with `HAZARD_STEP_EN`.

## Operation
- Hazard term: hz = exMemRead && exRt != 0 && (exRt == idRs || (idUsesRt && exRt == idRt)).
- States: RUN, STALL, FLUSH, plus HOLD under `HAZARD_STEP_EN`. Encoding is free.
- Next-state priority, evaluated at posedge, highest first:
  1. branchTaken → FLUSH and load flushCnt = FLUSH_CYCLES-1. This applies from any state, including an active FLUSH, which restarts the window.
  2. FLUSH with flushCnt != 0 → stay in FLUSH and decrement flushCnt.
  3. hz with state != STALL → STALL.
  4. Otherwise → RUN.
- STALL always lasts exactly one cycle. A hz still present in STALL does not extend it.
- Registered outputs by next state:
  - RUN: pcWrite=1, ifIdWrite=1, inHazard=0, flush=0.
  - STALL: pcWrite=0, ifIdWrite=0, inHazard=1, flush=0.
  - FLUSH: pcWrite=1, ifIdWrite=1, inHazard=0, flush=1.
- stallCount increments on each entry to STALL.
- flushCount increments on each cycle where branchTaken=1, including restarts.
- Both counters saturate at 2^CNT_W-1 and do not wrap.
- Reset (asynchronous, any state, mid-stall or mid-flush): state=RUN, pcWrite=1, ifIdWrite=1, inHazard=0, flush=0, stallCount=0, flushCount=0, flushCnt=0.

## Timing
- Inputs are sampled at posedge N. Outputs are valid from posedge N (clock-to-q) through posedge N+1.
- The ID register captures on the negedge, half a cycle after the outputs update.
- Latency from hz to inHazard=1 is one posedge. The bubble occupies exactly one cycle.
- Latency from branchTaken to flush=1 is one posedge. flush stays high for exactly FLUSH_CYCLES cycles unless restarted.
- branchTaken and hz in the same cycle: FLUSH wins. No stall is inserted and stallCount is unchanged.
- hz seen again immediately after STALL ends: a new STALL is allowed. The minimum spacing between stalls is one RUN cycle.

## Configuration
- Macro: `HAZARD_STEP_EN`.
- Defined:
  - Adds the `stepMode` and `stepReq` ports and the HOLD state.
  - With stepMode=1 and no branchTaken, the next state is HOLD. HOLD outputs are pcWrite=0, ifIdWrite=0, inHazard=1, flush=0.
  - A rising edge of `stepReq` while in HOLD gives one RUN cycle (normal outputs), then HOLD again. stepReq is registered internally for edge detection.
  - A pending STALL or FLUSH takes priority over HOLD and completes first.
  - stepMode=0 returns to RUN on the next posedge.
- Undefined: the ports and HOLD state are absent, and behaviour is exactly as in Operation.

## Test plan
- Load-use on rs: exMemRead=1, exRt=5, idRs=5 for one cycle → inHazard=1, pcWrite=0, ifIdWrite=0 for exactly one cycle; stallCount 0→1.
- Register $0 and the rt gate: exRt=0, idRs=0 → no stall. Then exRt=7, idRt=7, idUsesRt=0 → no stall. Then idUsesRt=1 → one stall.
- Flush length: FLUSH_CYCLES=3, branchTaken pulsed one cycle → flush=1 for exactly 3 cycles, pcWrite=1 throughout, flushCount=1. A second pulse during cycle 2 → window restarts, flush high for 3 more cycles, flushCount=2.
- Simultaneous events: branchTaken=1 and hz=1 in the same cycle → flush=1, inHazard=0, stallCount unchanged.
- Reset mid-operation: assert reset during STALL and during FLUSH → outputs return to 1,1,0,0 and counters to 0 immediately, without waiting for a clock edge. Separately, force stallCount to 16'hFFFF → further stalls leave it at 16'hFFFF.
- With `HAZARD_STEP_EN`: stepMode=1 → pcWrite=0 held; each stepReq rising edge → exactly one cycle with pcWrite=1; stepMode=0 → RUN on the next posedge.

Source files
------------

// File: rtl/hazard_sched.sv
// hazard_sched: load-use stall and branch-flush sequencer for the ID stage.
// Optional single-step debug (stepMode/stepReq, HOLD state) is compiled in
// with the HAZARD_STEP_EN macro; the default build omits it.
//
// state | meaning
// RUN   | normal flow, PC and IF/ID advance
// STALL | one-cycle load-use bubble, PC and IF/ID frozen
// FLUSH | ID/EX cleared for FLUSH_CYCLES cycles after a taken branch
// HOLD  | single-step hold (HAZARD_STEP_EN only), pipeline frozen
module hazard_sched #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  input  logic             branchTaken,
`ifdef HAZARD_STEP_EN
  input  logic             stepMode,
  input  logic             stepReq,
`endif
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             inHazard,
  output logic             flush,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

`ifdef HAZARD_STEP_EN
  typedef enum logic [1:0] {RUN, STALL, FLUSH, HOLD} state_t;
`else
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
`endif

  // window counter holds remaining flush cycles after the current one
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic       hz;
  logic       stall_entry;

`ifdef HAZARD_STEP_EN
  logic step_req_q;
  logic step_rise;
  assign step_rise = stepReq && !step_req_q;
`endif

  assign hz = exMemRead && (exRt != 5'd0) &&
              ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

  // a stall is never re-entered directly from STALL, so every STALL is an entry
  assign stall_entry = (state_nxt == STALL) && (state != STALL);

  // next-state selection: branch > running flush window > hazard > step hold > run
  always_comb begin
    state_nxt     = RUN;
    flush_cnt_nxt = flush_cnt;
    if (branchTaken) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = FLUSH_LOAD;
    end else if ((state == FLUSH) && (flush_cnt != 4'd0)) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = flush_cnt - 4'd1;
    end else if (hz && (state != STALL)) begin
      state_nxt = STALL;
`ifdef HAZARD_STEP_EN
    end else if (stepMode && !((state == HOLD) && step_rise)) begin
      state_nxt = HOLD;
`endif
    end else begin
      state_nxt = RUN;
    end
  end

  // state, registered outputs decoded from the next state, saturating counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      flush_cnt  <= 4'd0;
      pcWrite    <= 1'b1;
      ifIdWrite  <= 1'b1;
      inHazard   <= 1'b0;
      flush      <= 1'b0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      pcWrite   <= (state_nxt == RUN) || (state_nxt == FLUSH);
      ifIdWrite <= (state_nxt == RUN) || (state_nxt == FLUSH);
      inHazard  <= !((state_nxt == RUN) || (state_nxt == FLUSH));
      flush     <= (state_nxt == FLUSH);
      if (stall_entry && (stallCount != '1))
        stallCount <= stallCount + CNT_W'(1);
      if (branchTaken && (flushCount != '1))
        flushCount <= flushCount + CNT_W'(1);
    end
  end

`ifdef HAZARD_STEP_EN
  // previous stepReq for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_req_q <= 1'b0;
    else       step_req_q <= stepReq;
  end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;
  localparam int F = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] idRs = '0, idRt = '0, exRt = '0;
  logic       idUsesRt = 1'b0, exMemRead = 1'b0, branchTaken = 1'b0;
`ifdef HAZARD_STEP_EN
  logic       stepMode = 1'b0, stepReq = 1'b0;
`endif

  logic        pcWrite, ifIdWrite, inHazard, flush;
  logic [15:0] stallCount, flushCount;
  logic        s_pcWrite, s_ifIdWrite, s_inHazard, s_flush;
  logic [2:0]  s_stallCount, s_flushCount;

  always #5 clk = ~clk;

  hazard_sched #(.FLUSH_CYCLES(F), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken),
`ifdef HAZARD_STEP_EN
    .stepMode(stepMode), .stepReq(stepReq),
`endif
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .inHazard(inHazard), .flush(flush),
    .stallCount(stallCount), .flushCount(flushCount));

  // narrow-counter copy on the same inputs exercises saturation quickly
  hazard_sched #(.FLUSH_CYCLES(F), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken),
`ifdef HAZARD_STEP_EN
    .stepMode(stepMode), .stepReq(stepReq),
`endif
    .pcWrite(s_pcWrite), .ifIdWrite(s_ifIdWrite), .inHazard(s_inHazard), .flush(s_flush),
    .stallCount(s_stallCount), .flushCount(s_flushCount));

  typedef struct packed {
    logic [3:0] outs;
    int         ns;
    int         nf;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // reference model: edge index, edge of last taken branch, stall history
  int cyc = 0;
  int last_br = -1000;
  bit stall_prev = 1'b0;
  int n_stall = 0;
  int n_flush = 0;

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic void chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endfunction

  function automatic void model_reset();
    last_br    = -1000;
    stall_prev = 1'b0;
    n_stall    = 0;
    n_flush    = 0;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] ert, input logic br);
    bit   hzm, fl, st;
    exp_t e;
    @(negedge clk);
    idRs = rs; idRt = rt; idUsesRt = uses; exMemRead = mr; exRt = ert; branchTaken = br;
    hzm = mr && (ert != 0) && ((ert == rs) || (uses && (ert == rt)));
    cyc++;
    if (br) begin
      last_br = cyc;
      n_flush++;
    end
    fl = (cyc - last_br) < F;
    st = !fl && hzm && !stall_prev;
    if (st) n_stall++;
    stall_prev = st;
    e.outs = {!st, !st, st, fl};
    e.ns   = n_stall;
    e.nf   = n_flush;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_outs"}, int'({pcWrite, ifIdWrite, inHazard, flush}), 12);
    chk({tag, "_stallCount"}, int'(stallCount), 0);
    chk({tag, "_flushCount"}, int'(flushCount), 0);
    chk({tag, "_sat_counts"}, int'({s_stallCount, s_flushCount}), 0);
  endtask

  // asynchronous reset between clock edges, checked before any edge occurs
  task automatic reset_mid(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state(tag);
    @(negedge clk);
    idRs = '0; idRt = '0; idUsesRt = 1'b0; exMemRead = 1'b0; exRt = '0; branchTaken = 1'b0;
    model_reset();
    reset = 1'b0;
  endtask

  // monitor: every post-edge output set is compared with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("outs", int'({pcWrite, ifIdWrite, inHazard, flush}), int'(e.outs));
        chk("stallCount", int'(stallCount), e.ns);
        chk("flushCount", int'(flushCount), e.nf);
        chk("sat_outs", int'({s_pcWrite, s_ifIdWrite, s_inHazard, s_flush}), int'(e.outs));
        chk("sat_stallCount", int'(s_stallCount), sat(e.ns, 7));
        chk("sat_flushCount", int'(s_flushCount), sat(e.nf, 7));
      end
    end
  end

  initial begin
    #12;
    check_reset_state("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // load-use on rs
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    idle(2);
    // $0 never hazards; rt only counts when read
    drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    drive(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0);
    drive(5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
    idle(2);
    // flush window and restart in its second cycle
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    idle(4);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    idle(1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    idle(4);
    // branch and hazard together
    drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1);
    idle(4);
    // persistent hazard alternates stall and run
    for (int i = 0; i < 5; i++) drive(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
    // hazard held across the end of a flush window
    drive(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1);
    for (int i = 0; i < 4; i++) drive(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
    idle(1);

    // reset during STALL and during FLUSH
    drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    reset_mid("reset_stall");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    idle(1);
    reset_mid("reset_flush");

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rs, rt, ert;
      logic       uses, mr, br;
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      ert  = 5'($urandom_range(0, 3));
      uses = 1'($urandom_range(0, 1));
      mr   = 1'($urandom_range(0, 1));
      br   = ($urandom_range(0, 6) == 0);
      drive(rs, rt, uses, mr, ert, br);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
